// File: rtl/data_ram_pkg.sv
// Shared definitions for the data_ram memory-stage RAM: default widths,
// w_r encoding and the index-width helper.
package data_ram_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;

  // w_r encoding on the shared address bus
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // Number of index bits needed to address depth words (depth is a power of two).
  function automatic int unsigned log2_depth(input int unsigned depth);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < depth) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/data_ram_decode.sv
// Address window decode for data_ram: flags a hit when addr lies inside
// [BASE_ADDR, BASE_ADDR+DEPTH-1] over the full bus width and produces the
// word index relative to BASE_ADDR.
module data_ram_decode
  import data_ram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DEPTH     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       IDX_W     = log2_depth(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  index
);

  logic [ADDR_W-1:0] offset;

  // The offset compare covers every upper bit, so there is no aliasing and
  // no wrap past BASE_ADDR+DEPTH-1 even when that sum overflows the bus.
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (addr >= BASE_ADDR) && (offset < ADDR_W'(DEPTH));
    index  = offset[IDX_W-1:0];
  end

endmodule

// File: rtl/data_ram.sv
// Single-port, word-addressed data RAM for the CPU memory stage.
// Registered read (one-cycle latency), writes commit on the clock edge,
// synchronous active-high reset clears every word and the read register.
// Optional: define DATA_RAM_OOR_ERR_EN to add the registered oor_err flag
// that reports writes aimed outside the address window.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DEPTH     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w_r,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
`ifdef DATA_RAM_OOR_ERR_EN
  ,
  output logic              oor_err
`endif
);

  localparam int unsigned IDX_W = log2_depth(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              hit;
  logic [IDX_W-1:0]  index;

  data_ram_decode #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr  (addr),
    .hit   (hit),
    .index (index)
  );

  // Storage and read register. Only an explicit WR writes; any other w_r
  // value on a hit falls through to the read path so memory is never
  // corrupted by an undriven control line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
      rd_data <= '0;
    end else if (hit) begin
      if (w_r == WR) begin
        mem[index] <= wr_data;
        rd_data    <= '0;
      end else begin
        rd_data <= mem[index];
      end
    end else begin
      rd_data <= '0;
    end
  end

`ifdef DATA_RAM_OOR_ERR_EN
  // Out-of-range write flag, valid for the cycle after the attempt.
  always_ff @(posedge clk) begin
    if (rst) oor_err <= 1'b0;
    else     oor_err <= !hit && (w_r == WR);
  end
`endif

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (DEPTH=32, BASE_ADDR=0): a word-level
// memory model checked every cycle plus hand-computed literal expectations.
module tb_data_ram;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam longint unsigned BASE = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              w_r = 1'b1;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data;
`ifdef DATA_RAM_OOR_ERR_EN
  logic              oor_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  data_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .w_r     (w_r),
    .wr_data (wr_data),
    .rd_data (rd_data)
`ifdef DATA_RAM_OOR_ERR_EN
    ,
    .oor_err (oor_err)
`endif
  );

  always #5 clk = ~clk;

  // Model state: plain word array plus expected outputs.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] exp_rd;
  logic              exp_oor;
  bit                model_valid = 0;

  // Model update from the spec rules, using the inputs sampled at the edge.
  always @(posedge clk) begin
    longint unsigned a;
    bit in_win;
    a = longint'(addr);
    in_win = (a >= BASE) && (a < BASE + DEPTH);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      exp_rd = '0;
      exp_oor = 1'b0;
      model_valid = 1;
    end else begin
      exp_oor = !in_win && (w_r === 1'b0);
      if (!in_win) begin
        exp_rd = '0;
      end else if (w_r === 1'b0) begin
        m_mem[int'(a - BASE)] = wr_data;
        exp_rd = '0;
      end else begin
        exp_rd = m_mem[int'(a - BASE)];
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      n_cmp++;
      if (rd_data !== exp_rd) begin
        n_bad++;
        $display("FAIL model_rd_data t=%0t got=%h exp=%h", $time, rd_data, exp_rd);
      end
`ifdef DATA_RAM_OOR_ERR_EN
      n_cmp++;
      if (oor_err !== exp_oor) begin
        n_bad++;
        $display("FAIL model_oor_err t=%0t got=%b exp=%b", $time, oor_err, exp_oor);
      end
`endif
    end
  end

  task automatic drive(input logic r, input logic [ADDR_W-1:0] a,
                       input logic wr, input logic [DATA_W-1:0] d);
    @(negedge clk);
    rst = r; addr = a; w_r = wr; wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [DATA_W-1:0] want);
    n_cmp++;
    if (rd_data !== want) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, rd_data, want);
    end
  endtask

`ifdef DATA_RAM_OOR_ERR_EN
  task automatic lit_oor(input string name, input logic want);
    n_cmp++;
    if (oor_err !== want) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", name, oor_err, want);
    end
  endtask
`endif

  initial begin
    // Reset, then read both ends of the window
    drive(1'b1, 32'h0, 1'b1, 32'h0);          lit("reset_rd", 32'h0);
    drive(1'b0, 32'h00, 1'b1, 32'h0);         lit("rd_after_reset_00", 32'h0);
    drive(1'b0, 32'h1F, 1'b1, 32'h0);         lit("rd_after_reset_1f", 32'h0);

    // Held writes
    for (int i = 0; i < 16; i++) drive(1'b0, 32'h01, 1'b0, 32'h1010_1010);
    lit("rd_during_write", 32'h0);

    // Out-of-range writes between the two held writes
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h1000_0000, 1'b0, 32'h0);
    lit("rd_during_miss", 32'h0);
`ifdef DATA_RAM_OOR_ERR_EN
    lit_oor("oor_err_on_miss_write", 1'b1);
`endif

    for (int i = 0; i < 16; i++) drive(1'b0, 32'h1F, 1'b0, 32'hFFFF_FFFF);
`ifdef DATA_RAM_OOR_ERR_EN
    lit_oor("oor_err_clear_on_hit", 1'b0);
`endif

    drive(1'b0, 32'h1F, 1'b1, 32'h0);         lit("rd_1f_first", 32'hFFFF_FFFF);
    drive(1'b0, 32'h1F, 1'b1, 32'h0);         lit("rd_1f_second", 32'hFFFF_FFFF);
    drive(1'b0, 32'h01, 1'b1, 32'h0);         lit("rd_01", 32'h1010_1010);

    // Boundary: BASE+DEPTH is outside the window
    drive(1'b0, 32'h20, 1'b0, 32'hA5A5_A5A5); lit("wr_20_ignored", 32'h0);
    drive(1'b0, 32'h20, 1'b1, 32'h0);         lit("rd_20_miss", 32'h0);
    drive(1'b0, 32'h00, 1'b1, 32'h0);         lit("rd_00_untouched", 32'h0);
    drive(1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0);  lit("rd_top_addr_miss", 32'h0);
    drive(1'b0, 32'h0000_0021, 1'b1, 32'h0);  lit("rd_21_miss", 32'h0);

    // Index 0 usable
    drive(1'b0, 32'h00, 1'b0, 32'h0BAD_F00D);
    drive(1'b0, 32'h00, 1'b1, 32'h0);         lit("rd_00_written", 32'h0BAD_F00D);

    // Read-after-write and streamed reads
    drive(1'b0, 32'h05, 1'b0, 32'h1234_5678);
    drive(1'b0, 32'h05, 1'b1, 32'h0);         lit("raw_05", 32'h1234_5678);
    drive(1'b0, 32'h01, 1'b1, 32'h0);         lit("stream_01", 32'h1010_1010);
    drive(1'b0, 32'h1F, 1'b1, 32'h0);         lit("stream_1f", 32'hFFFF_FFFF);

    // Reset mid-write discards the write and clears the array
    drive(1'b1, 32'h03, 1'b0, 32'hDEAD_BEEF); lit("rd_in_reset", 32'h0);
    drive(1'b0, 32'h03, 1'b1, 32'h0);         lit("rd_03_after_reset", 32'h0);
    drive(1'b0, 32'h1F, 1'b1, 32'h0);         lit("rd_1f_cleared", 32'h0);
    drive(1'b0, 32'h05, 1'b1, 32'h0);         lit("rd_05_cleared", 32'h0);

    drive(1'b0, 32'h00, 1'b1, 32'h0);
    drive(1'b0, 32'h00, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
